// File: rtl/rshift_decoder.sv
// Serial one-hot decoder: recovers n from a word expected to be (1 << n) by
// right-shifting it one bit per clock, and flags words that are not one-hot.
module rshift_decoder #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shifted_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit4_out,
  output logic             onehot_err,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a word; in_ready high
  // SHIFT | scanning sreg one bit per clock
  // DONE  | result presented; waiting for out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic [CNT_W-1:0] count, count_next;
  logic [CNT_W-1:0] pos, pos_next;
  logic [1:0]       ones, ones_next;
  logic [CNT_W-1:0] bit4_next;
  logic             err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      count      <= '0;
      pos        <= '0;
      ones       <= '0;
      bit4_out   <= '0;
      onehot_err <= 1'b0;
    end else begin
      state      <= state_next;
      sreg       <= sreg_next;
      count      <= count_next;
      pos        <= pos_next;
      ones       <= ones_next;
      bit4_out   <= bit4_next;
      onehot_err <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    count_next = count;
    pos_next   = pos;
    ones_next  = ones;
    bit4_next  = bit4_out;
    err_next   = onehot_err;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sreg_next  = shifted_in;
          count_next = '0;
          ones_next  = '0;
          pos_next   = '0;
          if (shifted_in == '0) begin
            state_next = DONE;
            bit4_next  = '0;
            err_next   = 1'b1;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (sreg[0]) begin
          if (ones == 2'd0) pos_next = count;
          // ones only needs to distinguish 0, 1 and "two or more"
          ones_next = (ones == 2'd2) ? 2'd2 : ones + 2'd1;
        end
        sreg_next  = sreg >> 1;
        count_next = count + 1'b1;
        if (sreg[WIDTH-1:1] == '0) begin
          state_next = DONE;
          bit4_next  = pos_next;
          err_next   = (ones_next != 2'd1);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rshift_decoder.sv
// Directed plus randomized bench for rshift_decoder; expectations come from a
// word-level model (lowest set bit, popcount, highest set bit).
module tb_rshift_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] shifted_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  bit4_out;
  logic        onehot_err;
  logic        busy;

  int passed = 0;
  int total  = 0;

  rshift_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .shifted_in (shifted_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bit4_out   (bit4_out),
    .onehot_err (onehot_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest_bit(input logic [15:0] w);
    for (int i = 0; i < 16; i++) if (w[i]) return i;
    return 0;
  endfunction

  function automatic int highest_bit(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) if (w[i]) return i;
    return 0;
  endfunction

  // Full transaction: accept w, hold garbage on the input while busy,
  // stall the consumer for `stall` cycles in DONE, then complete the handshake.
  task automatic run_word(input string tag, input logic [15:0] w, input int stall);
    int lat;
    int exp_lat;
    logic [3:0] held;
    exp_lat = (w == 16'h0) ? 0 : highest_bit(w) + 1;
    chk({tag, ":in_ready_pre"}, in_ready, 1);
    in_valid   = 1'b1;
    shifted_in = w;
    out_ready  = 1'b0;
    step();
    shifted_in = ~w;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) chk({tag, ":in_ready_shift"}, in_ready, 0);
      step();
      lat++;
    end
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":bit4_out"}, bit4_out, lowest_bit(w));
    chk({tag, ":onehot_err"}, onehot_err, ($countones(w) != 1));
    held = bit4_out;
    for (int i = 0; i < stall; i++) begin
      step();
      if (!out_valid || in_ready || bit4_out !== held) begin
        chk({tag, ":stall_out_valid"}, out_valid, 1);
        chk({tag, ":stall_in_ready"}, in_ready, 0);
        chk({tag, ":stall_bit4"}, bit4_out, held);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ":in_ready_post"}, in_ready, 1);
    chk({tag, ":out_valid_post"}, out_valid, 0);
    chk({tag, ":bit4_kept"}, bit4_out, held);
  endtask

  initial begin
    logic [15:0] w;
    int seen;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    shifted_in = 16'h0;
    step();
    step();
    rst = 1'b0;
    chk("reset:in_ready", in_ready, 1);
    chk("reset:out_valid", out_valid, 0);
    chk("reset:bit4_out", bit4_out, 0);
    chk("reset:onehot_err", onehot_err, 0);
    chk("reset:busy", busy, 0);

    run_word("t1", 16'h0001, 0);
    run_word("t2", 16'h2000, 0);
    run_word("t3", 16'h0100, 5);
    run_word("t4", 16'h0000, 0);
    run_word("t5", 16'h0120, 1);

    // Reset during the 4th SHIFT cycle discards the word
    in_valid   = 1'b1;
    shifted_in = 16'h8000;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("t6:busy_before_rst", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6:in_ready", in_ready, 1);
    chk("t6:bit4_out", bit4_out, 0);
    chk("t6:onehot_err", onehot_err, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("t6:no_out_valid", seen, 0);
    run_word("t6b", 16'h0004, 0);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0:       w = 16'h1 << $urandom_range(0, 15);
        1:       w = 16'h0;
        default: w = 16'($urandom);
      endcase
      run_word("rand", w, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
